axis_packetizer: RTL and testbench

- Sits directly downstream of the FIFO-fed sample streamer and consumes its 16-bit valid/ready sample stream.
- Frames samples into fixed-length packets in this order:
  - sync word
  - sequence-number word
  - PKT_LEN payload samples
  - 16-bit checksum word, flagged with m_last
- Single sys_clk domain; output is a registered valid/ready stream to the link/DMA stage.

---
 rtl/adc_pkt_pkg.sv | 30 +++
 rtl/axis_packetizer.sv | 172 +++++++++++++++++
 tb/tb_axis_packetizer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkt_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkt_pkg
// Shared types and constants for the sample-stream packetizer.
//   pkt_state_e   : packetizer FSM states
//   SAMPLE_W      : width of one sample / output word
//   SYNC_WORD_DEF : default first word of every packet
//   wrap_add16    : modulo-2^16 addition used for the payload checksum
// ---------------------------------------------------------------------------
package adc_pkt_pkg;

   localparam int SAMPLE_W = 16;

   localparam logic [SAMPLE_W-1:0] SYNC_WORD_DEF = 16'hA55A;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SYNC      = 3'd1,
      SEQ       = 3'd2,
      PAYLOAD   = 3'd3,
      CSUM      = 3'd4,
      WAIT_LAST = 3'd5
   } pkt_state_e;

   // Carry out of bit 15 is dropped on purpose: the checksum wraps.
   function automatic logic [SAMPLE_W-1:0] wrap_add16(input logic [SAMPLE_W-1:0] a,
                                                       input logic [SAMPLE_W-1:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------
// axis_packetizer
// Frames a 16-bit valid/ready sample stream into fixed-length packets:
//   SYNC_WORD, sequence number, PKT_LEN payload samples, checksum (m_last).
// The checksum is the 16-bit wrap-around sum of the payload words only.
//
// Ports
//   sys_clk     : system clock, rising edge
//   sys_rst     : synchronous active-high reset
//   enable      : permits a new packet to start (looked at in IDLE/WAIT_LAST)
//   s_valid/s_ready/s_data : upstream sample stream
//   m_valid/m_ready/m_data/m_last : registered downstream word stream
//   busy        : FSM is not in IDLE
//   pkt_done    : one-cycle pulse after the checksum word is accepted
//   o_dbg_state : current FSM state (pkt_state_e encoding)
//
// Handshake: a beat happens on a rising edge where valid && ready. Valid
// never waits on ready; once m_valid is raised, m_data/m_last hold until the
// beat. s_ready is combinational from m_ready and never looks at s_valid.
// ---------------------------------------------------------------------------
module axis_packetizer
   import adc_pkt_pkg::*;
#(
   parameter int                  PKT_LEN   = 64,
   parameter logic [SAMPLE_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
   parameter logic [SAMPLE_W-1:0] SEQ_INIT  = 16'h0000
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                enable,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [SAMPLE_W-1:0] m_data,
   output logic                m_last,
   output logic                busy,
   output logic                pkt_done,
   output logic [2:0]          o_dbg_state
);

   // Count value on which the final payload beat is taken.
   localparam logic [15:0] LP_CNT_LAST = 16'(PKT_LEN - 1);

   pkt_state_e          r_state;
   logic [15:0]         r_seq;
   logic [SAMPLE_W-1:0] r_sum;
   logic [15:0]         r_cnt;
   logic                r_m_valid;
   logic [SAMPLE_W-1:0] r_m_data;
   logic                r_m_last;
   logic                r_pkt_done;

   pkt_state_e          w_next_state;
   logic                w_slot_free;
   logic                w_in_beat;
   logic                w_last_beat;
   logic                w_load;
   logic [SAMPLE_W-1:0] w_load_data;
   logic                w_load_last;
   logic [15:0]         w_next_seq;
   logic [SAMPLE_W-1:0] w_next_sum;
   logic [15:0]         w_next_cnt;
   logic                w_done;

   // The single output slot can take a new word when empty or draining.
   assign w_slot_free = !r_m_valid || m_ready;
   assign s_ready     = (r_state == PAYLOAD) && w_slot_free;
   assign w_in_beat   = s_valid && s_ready;
   assign w_last_beat = r_m_valid && m_ready && r_m_last;

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_load_data  = r_m_data;
      w_load_last  = 1'b0;
      w_next_seq   = r_seq;
      w_next_sum   = r_sum;
      w_next_cnt   = r_cnt;
      w_done       = 1'b0;

      case (r_state)
         IDLE: begin
            if (enable) w_next_state = SYNC;
         end
         SYNC: begin
            if (w_slot_free) begin
               w_load       = 1'b1;
               w_load_data  = SYNC_WORD;
               w_next_state = SEQ;
            end
         end
         SEQ: begin
            if (w_slot_free) begin
               w_load       = 1'b1;
               w_load_data  = r_seq;
               w_next_sum   = '0;
               w_next_cnt   = '0;
               w_next_state = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (w_in_beat) begin
               w_load      = 1'b1;
               w_load_data = s_data;
               w_next_sum  = wrap_add16(r_sum, s_data);
               w_next_cnt  = r_cnt + 16'd1;
               if (r_cnt == LP_CNT_LAST) w_next_state = CSUM;
            end
         end
         CSUM: begin
            if (w_slot_free) begin
               w_load       = 1'b1;
               w_load_data  = r_sum;
               w_load_last  = 1'b1;
               w_next_state = WAIT_LAST;
            end
         end
         WAIT_LAST: begin
            if (w_last_beat) begin
               w_done     = 1'b1;
               w_next_seq = r_seq + 16'd1;
               if (enable) begin
                  // The checksum leaves this cycle, so the slot is free and
                  // the next SYNC word goes straight in: no gap between packets.
                  w_load       = 1'b1;
                  w_load_data  = SYNC_WORD;
                  w_next_state = SEQ;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state    <= IDLE;
         r_seq      <= SEQ_INIT;
         r_sum      <= '0;
         r_cnt      <= '0;
         r_m_valid  <= 1'b0;
         r_m_data   <= '0;
         r_m_last   <= 1'b0;
         r_pkt_done <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_seq      <= w_next_seq;
         r_sum      <= w_next_sum;
         r_cnt      <= w_next_cnt;
         r_pkt_done <= w_done;
         if (w_slot_free) begin
            r_m_valid <= w_load;
            if (w_load) begin
               r_m_data <= w_load_data;
               r_m_last <= w_load_last;
            end
         end
      end
   end

   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign m_last      = r_m_last;
   assign pkt_done    = r_pkt_done;
   assign busy        = (r_state != IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axis_packetizer.sv
// ---------------------------------------------------------------------------
// tb_axis_packetizer
// Three packetizer instances with different parameters:
//   0: PKT_LEN=4, SEQ_INIT=0000   1: PKT_LEN=2, SEQ_INIT=FFFF
//   2: PKT_LEN=1, SEQ_INIT=0000
// Expected words are pushed into per-instance queues as {last, data}; one
// monitor pops and compares on every output beat and checks hold stability.
// ---------------------------------------------------------------------------
module tb_axis_packetizer;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        enable  [3];
   logic        s_valid [3];
   logic        s_ready [3];
   logic [15:0] s_data  [3];
   logic        m_valid [3];
   logic        m_ready [3] = '{1'b1, 1'b1, 1'b1};
   logic [15:0] m_data  [3];
   logic        m_last  [3];
   logic        busy    [3];
   logic        pkt_done[3];
   logic [2:0]  dbg_state[3];

   logic [16:0] exp_q0[$];
   logic [16:0] exp_q1[$];
   logic [16:0] exp_q2[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int done_cnt [3];
   int beat_num [3];
   int first_cyc[3];
   int last_cyc [3];
   int ready_mode = 0;
   logic [15:0] pay[8];

   always #5 sys_clk = ~sys_clk;

   axis_packetizer #(.PKT_LEN(4), .SYNC_WORD(16'hA55A), .SEQ_INIT(16'h0000)) u_dut0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable[0]),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]),
      .busy(busy[0]), .pkt_done(pkt_done[0]), .o_dbg_state(dbg_state[0]));

   axis_packetizer #(.PKT_LEN(2), .SYNC_WORD(16'hA55A), .SEQ_INIT(16'hFFFF)) u_dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable[1]),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]),
      .busy(busy[1]), .pkt_done(pkt_done[1]), .o_dbg_state(dbg_state[1]));

   axis_packetizer #(.PKT_LEN(1), .SYNC_WORD(16'hA55A), .SEQ_INIT(16'h0000)) u_dut2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable[2]),
      .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]),
      .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]), .m_last(m_last[2]),
      .busy(busy[2]), .pkt_done(pkt_done[2]), .o_dbg_state(dbg_state[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic push(input int k, input logic last, input logic [15:0] d);
      case (k)
         0: exp_q0.push_back({last, d});
         1: exp_q1.push_back({last, d});
         default: exp_q2.push_back({last, d});
      endcase
   endtask

   function automatic int q_size(input int k);
      case (k)
         0: return exp_q0.size();
         1: return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   // Downstream ready pattern: 0 = always ready, 1 = toggle every cycle.
   always @(posedge sys_clk) begin
      #1;
      for (int k = 0; k < 3; k++)
         m_ready[k] = (ready_mode == 1) ? !m_ready[k] : 1'b1;
   end

   // Monitor / scoreboard.
   logic        prev_stall[3] = '{1'b0, 1'b0, 1'b0};
   logic [16:0] prev_word [3];
   always @(negedge sys_clk) begin
      logic [16:0] got;
      logic [16:0] exp;
      cyc++;
      for (int k = 0; k < 3; k++) begin
         got = {m_last[k], m_data[k]};
         if (pkt_done[k] === 1'b1) done_cnt[k]++;
         if (prev_stall[k]) chk($sformatf("hold_stable[%0d]", k), {15'd0, got}, {15'd0, prev_word[k]});
         prev_stall[k] = m_valid[k] && !m_ready[k] && !sys_rst;
         prev_word[k]  = got;
         if (m_valid[k] === 1'b1 && m_ready[k] === 1'b1) begin
            if (q_size(k) == 0) begin
               n_checks++;
               $display("FAIL unexpected_word[%0d]: got %h expected no word", k, got);
            end else begin
               case (k)
                  0: exp = exp_q0.pop_front();
                  1: exp = exp_q1.pop_front();
                  default: exp = exp_q2.pop_front();
               endcase
               chk($sformatf("out_word[%0d]", k), {15'd0, got}, {15'd0, exp});
            end
            if (beat_num[k] == 0) first_cyc[k] = cyc;
            last_cyc[k] = cyc;
            beat_num[k]++;
         end
      end
   end

   task automatic clear_stats(input int k);
      done_cnt[k]  = 0;
      beat_num[k]  = 0;
      first_cyc[k] = 0;
      last_cyc[k]  = 0;
   endtask

   task automatic do_reset();
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         enable[k]  = 1'b0;
         s_valid[k] = 1'b0;
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_m_valid", {31'd0, m_valid[k]}, 32'd0);
         chk("rst_m_data", {16'd0, m_data[k]}, 32'd0);
         chk("rst_m_last", {31'd0, m_last[k]}, 32'd0);
         chk("rst_busy", {31'd0, busy[k]}, 32'd0);
         chk("rst_pkt_done", {31'd0, pkt_done[k]}, 32'd0);
      end
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
   endtask

   // Sends pay[0..n-1]; drops enable right after beat index drop_at.
   task automatic stream(input int k, input int n, input int drop_at, input bit gaps);
      bit accepted;
      int t;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               s_valid[k] = 1'b0;
               @(posedge sys_clk); #1;
            end
         end
         s_valid[k] = 1'b1;
         s_data[k]  = pay[i];
         accepted   = 1'b0;
         t          = 0;
         while (!accepted && t < 300) begin
            @(negedge sys_clk);
            t++;
            if (s_ready[k]) accepted = 1'b1;
            @(posedge sys_clk); #1;
         end
         chk("input_accept", {31'd0, accepted}, 32'd1);
         if (i == drop_at) enable[k] = 1'b0;
      end
      s_valid[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int target);
      int t = 0;
      while (done_cnt[k] < target && t < 500) begin
         @(negedge sys_clk);
         t++;
      end
      @(negedge sys_clk);
      chk("pkt_done_count", done_cnt[k], target);
      chk("queue_drained", q_size(k), 0);
   endtask

   task automatic wait_q_empty(input int k);
      int t = 0;
      while (q_size(k) != 0 && t < 300) begin
         @(negedge sys_clk);
         t++;
      end
      chk("queue_empty_wait", q_size(k), 0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         enable[k]  = 1'b0;
         s_valid[k] = 1'b0;
         s_data[k]  = '0;
         clear_stats(k);
      end
      do_reset();

      // Basic packet, enable dropped mid-packet.
      clear_stats(0);
      pay[0] = 16'h0001; pay[1] = 16'h0002; pay[2] = 16'h0003; pay[3] = 16'h0004;
      push(0, 0, 16'hA55A); push(0, 0, 16'h0000);
      push(0, 0, 16'h0001); push(0, 0, 16'h0002); push(0, 0, 16'h0003); push(0, 0, 16'h0004);
      push(0, 1, 16'h000A);
      enable[0] = 1'b1;
      stream(0, 4, 0, 1'b0);
      wait_done(0, 1);
      chk("t1_beats", beat_num[0], 7);
      chk("t1_span", last_cyc[0] - first_cyc[0], 6);
      chk("t1_busy_after", {31'd0, busy[0]}, 32'd0);
      s_valid[0] = 1'b1; s_data[0] = 16'h5555;
      repeat (4) begin
         @(negedge sys_clk);
         chk("t1_sready_idle", {31'd0, s_ready[0]}, 32'd0);
      end
      s_valid[0] = 1'b0;
      @(posedge sys_clk); #1;

      // Two back-to-back packets, continuous input; checksum wraps in pkt 2.
      do_reset();
      clear_stats(0);
      pay[0] = 16'h000A; pay[1] = 16'h0014; pay[2] = 16'h001E; pay[3] = 16'h0028;
      pay[4] = 16'hFFF0; pay[5] = 16'h0010; pay[6] = 16'h1234; pay[7] = 16'h0001;
      push(0, 0, 16'hA55A); push(0, 0, 16'h0000);
      push(0, 0, 16'h000A); push(0, 0, 16'h0014); push(0, 0, 16'h001E); push(0, 0, 16'h0028);
      push(0, 1, 16'h0064);
      push(0, 0, 16'hA55A); push(0, 0, 16'h0001);
      push(0, 0, 16'hFFF0); push(0, 0, 16'h0010); push(0, 0, 16'h1234); push(0, 0, 16'h0001);
      push(0, 1, 16'h1235);
      enable[0] = 1'b1;
      stream(0, 8, 4, 1'b0);
      wait_done(0, 2);
      chk("t2_beats", beat_num[0], 14);
      chk("t2_span_no_gap", last_cyc[0] - first_cyc[0], 13);

      // Toggling m_ready with random input gaps.
      do_reset();
      clear_stats(0);
      ready_mode = 1;
      pay[0] = 16'h0007; pay[1] = 16'h0008; pay[2] = 16'h0009; pay[3] = 16'h000A;
      push(0, 0, 16'hA55A); push(0, 0, 16'h0000);
      push(0, 0, 16'h0007); push(0, 0, 16'h0008); push(0, 0, 16'h0009); push(0, 0, 16'h000A);
      push(0, 1, 16'h0022);
      enable[0] = 1'b1;
      stream(0, 4, 0, 1'b1);
      wait_done(0, 1);
      ready_mode = 0;
      @(posedge sys_clk); #1;

      // Reset in the middle of PAYLOAD, then a full packet restarting at SEQ_INIT.
      do_reset();
      clear_stats(0);
      pay[0] = 16'h0005; pay[1] = 16'h0006;
      push(0, 0, 16'hA55A); push(0, 0, 16'h0000); push(0, 0, 16'h0005); push(0, 0, 16'h0006);
      enable[0] = 1'b1;
      stream(0, 2, -1, 1'b0);
      wait_q_empty(0);
      chk("t4_busy_mid", {31'd0, busy[0]}, 32'd1);
      @(posedge sys_clk); #1;
      sys_rst   = 1'b1;
      enable[0] = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("t4_rst_m_valid", {31'd0, m_valid[0]}, 32'd0);
      chk("t4_rst_busy", {31'd0, busy[0]}, 32'd0);
      @(posedge sys_clk); #1;
      sys_rst = 1'b0;
      pay[0] = 16'h0001; pay[1] = 16'h0002; pay[2] = 16'h0003; pay[3] = 16'h0004;
      push(0, 0, 16'hA55A); push(0, 0, 16'h0000);
      push(0, 0, 16'h0001); push(0, 0, 16'h0002); push(0, 0, 16'h0003); push(0, 0, 16'h0004);
      push(0, 1, 16'h000A);
      enable[0] = 1'b1;
      stream(0, 4, 0, 1'b0);
      wait_done(0, 1);

      // PKT_LEN=2, SEQ_INIT=FFFF: checksum wrap and sequence wrap.
      clear_stats(1);
      pay[0] = 16'hFFFF; pay[1] = 16'h0002; pay[2] = 16'h0003; pay[3] = 16'h0004;
      push(1, 0, 16'hA55A); push(1, 0, 16'hFFFF); push(1, 0, 16'hFFFF); push(1, 0, 16'h0002);
      push(1, 1, 16'h0001);
      push(1, 0, 16'hA55A); push(1, 0, 16'h0000); push(1, 0, 16'h0003); push(1, 0, 16'h0004);
      push(1, 1, 16'h0007);
      enable[1] = 1'b1;
      stream(1, 4, 2, 1'b0);
      wait_done(1, 2);
      chk("t5_span_no_gap", last_cyc[1] - first_cyc[1], 9);

      // PKT_LEN=1: checksum equals the single payload word.
      clear_stats(2);
      pay[0] = 16'h1234;
      push(2, 0, 16'hA55A); push(2, 0, 16'h0000); push(2, 0, 16'h1234); push(2, 1, 16'h1234);
      enable[2] = 1'b1;
      stream(2, 1, 0, 1'b0);
      wait_done(2, 1);
      chk("t6_beats", beat_num[2], 4);

      repeat (3) @(negedge sys_clk);
      for (int k = 0; k < 3; k++) chk("final_queue_empty", q_size(k), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
